// File: rtl/penalty_ctl.sv
`default_nettype none
// penalty_ctl: penalty-shootout sequencer. Aims on mouse click, animates the ball
// for a fixed number of frames, scores against a pseudo-random keeper position.
module penalty_ctl #(
  parameter int GOAL_X_MIN    = 300,
  parameter int GOAL_X_MAX    = 724,
  parameter int KEEPER_W      = 128,
  parameter int SHOTS         = 5,
  parameter int FLIGHT_FRAMES = 32,
  parameter int RESULT_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  output logic [2:0]  state,
  output logic [11:0] aim_x,
  output logic [11:0] keeper_xpos,
  output logic [2:0]  shot_cnt,
  output logic [2:0]  goal_cnt,
  output logic        goal,
  output logic [5:0]  flight_cnt
);

  localparam logic [2:0] ST_START  = 3'd0;
  localparam logic [2:0] ST_AIM    = 3'd1;
  localparam logic [2:0] ST_FLIGHT = 3'd2;
  localparam logic [2:0] ST_RESULT = 3'd3;
  localparam logic [2:0] ST_OVER   = 3'd4;

  localparam int RES_W = $clog2(RESULT_FRAMES + 1);

  logic             left_q;
  logic             armed_q;
  logic [7:0]       lfsr_q;
  logic [2:0]       state_q, state_d;
  logic [11:0]      aim_q, aim_d;
  logic [11:0]      keeper_q, keeper_d;
  logic [2:0]       shot_q, shot_d;
  logic [2:0]       gcnt_q, gcnt_d;
  logic             goal_q, goal_d;
  logic [5:0]       flight_q, flight_d;
  logic [RES_W-1:0] res_q, res_d;

  logic        click;
  logic [12:0] aim13, kp13, kp_end13;
  logic        in_mouth, in_keeper, shot_goal;

  // armed_q blocks a click from a button already held when reset is released
  always_comb begin
    click     = mouse_left & ~left_q & armed_q;
    aim13     = {1'b0, aim_q};
    kp13      = {1'b0, keeper_q};
    kp_end13  = kp13 + 13'(KEEPER_W);
    in_mouth  = (aim13 >= 13'(GOAL_X_MIN)) && (aim13 <= 13'(GOAL_X_MAX));
    in_keeper = (aim13 >= kp13) && (aim13 < kp_end13);
    shot_goal = in_mouth & ~in_keeper;
  end

  always_comb begin
    state_d  = state_q;
    aim_d    = aim_q;
    keeper_d = keeper_q;
    shot_d   = shot_q;
    gcnt_d   = gcnt_q;
    goal_d   = goal_q;
    flight_d = flight_q;
    res_d    = res_q;
    case (state_q)
      ST_START: begin
        if (click) begin
          state_d = ST_AIM;
          shot_d  = 3'd0;
          gcnt_d  = 3'd0;
          goal_d  = 1'b0;
        end
      end
      ST_AIM: begin
        if (click) begin
          state_d  = ST_FLIGHT;
          aim_d    = mouse_xpos;
          keeper_d = 12'(GOAL_X_MIN) + {4'd0, lfsr_q};
          flight_d = 6'd0;
        end
      end
      ST_FLIGHT: begin
        if (frame_tick) begin
          flight_d = flight_q + 6'd1;
          if (flight_q == 6'(FLIGHT_FRAMES - 1)) begin
            state_d = ST_RESULT;
            goal_d  = shot_goal;
            shot_d  = shot_q + 3'd1;
            gcnt_d  = gcnt_q + {2'd0, shot_goal};
            res_d   = '0;
          end
        end
      end
      ST_RESULT: begin
        if (frame_tick) begin
          if (res_q == RES_W'(RESULT_FRAMES - 1)) begin
            res_d   = '0;
            state_d = (shot_q == 3'(SHOTS)) ? ST_OVER : ST_AIM;
          end else begin
            res_d = res_q + 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (click) state_d = ST_START;
      end
      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_q   <= 1'b0;
      armed_q  <= 1'b0;
      lfsr_q   <= 8'hA5;
      state_q  <= ST_START;
      aim_q    <= 12'd0;
      keeper_q <= 12'd0;
      shot_q   <= 3'd0;
      gcnt_q   <= 3'd0;
      goal_q   <= 1'b0;
      flight_q <= 6'd0;
      res_q    <= '0;
    end else begin
      left_q   <= mouse_left;
      armed_q  <= armed_q | ~mouse_left;
      // taps 8,6,5,4: maximal length, never reaches zero from a nonzero seed
      lfsr_q   <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      state_q  <= state_d;
      aim_q    <= aim_d;
      keeper_q <= keeper_d;
      shot_q   <= shot_d;
      gcnt_q   <= gcnt_d;
      goal_q   <= goal_d;
      flight_q <= flight_d;
      res_q    <= res_d;
    end
  end

  assign state       = state_q;
  assign aim_x       = aim_q;
  assign keeper_xpos = keeper_q;
  assign shot_cnt    = shot_q;
  assign goal_cnt    = gcnt_q;
  assign goal        = goal_q;
  assign flight_cnt  = flight_q;

endmodule

`default_nettype wire

// File: tb/tb_penalty_ctl.sv
`default_nettype none
// tb_penalty_ctl: randomized game play against a shot-level reference model.
module tb_penalty_ctl;

  localparam int GX0   = 300;
  localparam int GX1   = 724;
  localparam int KW    = 128;
  localparam int NSHOT = 5;
  localparam int FF    = 32;
  localparam int RF    = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        mouse_left = 1'b0;
  logic [11:0] mouse_xpos = 12'd0;
  logic [2:0]  state;
  logic [11:0] aim_x;
  logic [11:0] keeper_xpos;
  logic [2:0]  shot_cnt;
  logic [2:0]  goal_cnt;
  logic        goal;
  logic [5:0]  flight_cnt;

  penalty_ctl #(
    .GOAL_X_MIN(GX0), .GOAL_X_MAX(GX1), .KEEPER_W(KW),
    .SHOTS(NSHOT), .FLIGHT_FRAMES(FF), .RESULT_FRAMES(RF)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .mouse_left(mouse_left),
    .mouse_xpos(mouse_xpos), .state(state), .aim_x(aim_x),
    .keeper_xpos(keeper_xpos), .shot_cnt(shot_cnt), .goal_cnt(goal_cnt),
    .goal(goal), .flight_cnt(flight_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int m_shots  = 0;
  int m_goals  = 0;
  logic [7:0] m_lfsr;

  function automatic logic [7:0] lf_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 8'hA5;
    else      m_lfsr <= lf_next(m_lfsr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit exp_goal(input int x, input int k);
    return (x >= GX0) && (x <= GX1) && !((x >= k) && (x < k + KW));
  endfunction

  task automatic click();
    @(negedge clk); mouse_left = 1'b1;
    @(negedge clk); mouse_left = 1'b0;
  endtask

  // One complete shot from AIM, including ignored clicks in FLIGHT and RESULT.
  task automatic do_shot(input logic [11:0] x, input bit with_tick);
    int k;
    bit g;
    @(negedge clk);
    mouse_xpos = x; mouse_left = 1'b1; frame_tick = with_tick;
    k = GX0 + int'(m_lfsr);
    @(negedge clk);
    mouse_left = 1'b0; frame_tick = 1'b0;
    check_eq("enter_flight", state, 2);
    check_eq("aim_x", aim_x, x);
    check_eq("keeper_xpos", keeper_xpos, k);
    check_eq("flight_cnt_start", flight_cnt, 0);
    g = exp_goal(int'(x), k);
    for (int i = 1; i <= FF; i++) begin
      frame_tick = 1'b1; mouse_left = (i == 10);
      @(negedge clk);
      frame_tick = 1'b0; mouse_left = 1'b0;
      if (i == FF - 1) begin
        check_eq("still_flight", state, 2);
        check_eq("flight_cnt_last", flight_cnt, FF - 1);
      end
      @(negedge clk);
    end
    m_shots++;
    m_goals += int'(g);
    check_eq("enter_result", state, 3);
    check_eq("goal", goal, g);
    check_eq("shot_cnt", shot_cnt, m_shots);
    check_eq("goal_cnt", goal_cnt, m_goals);
    for (int i = 1; i <= RF; i++) begin
      frame_tick = 1'b1; mouse_left = (i == 5);
      @(negedge clk);
      frame_tick = 1'b0; mouse_left = 1'b0;
      if (i == RF - 1) check_eq("still_result", state, 3);
      @(negedge clk);
    end
    check_eq("after_result", state, (m_shots == NSHOT) ? 4 : 1);
  endtask

  initial begin
    int entries;
    int k;
    bit g;
    logic [2:0] prev;
    logic [11:0] x;

    #1;
    check_eq("rst_state", state, 0);
    check_eq("rst_aim_x", aim_x, 0);
    check_eq("rst_keeper", keeper_xpos, 0);
    check_eq("rst_counts", {shot_cnt, goal_cnt, goal, flight_cnt}, 0);

    // button held through reset release must not count as a click
    mouse_left = 1'b1;
    @(negedge clk); rst = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("held_at_release", state, 0);
    mouse_left = 1'b0;
    @(negedge clk);
    click();
    check_eq("start_to_aim", state, 1);
    check_eq("aim_shot_cnt", shot_cnt, 0);

    do_shot(12'd100, 1'b0);
    do_shot(12'd700, 1'b0);

    // held button: exactly one flight, then back to AIM without re-firing
    x = 12'($urandom_range(150, 900));
    entries = 0;
    k = 0;
    for (int i = 0; i < 1000; i++) begin
      prev = state;
      mouse_left = 1'b1; mouse_xpos = x; frame_tick = (i % 2 == 1);
      if (i == 0) k = GX0 + int'(m_lfsr);
      @(negedge clk);
      if (state == 3'd2 && prev != 3'd2) entries++;
    end
    mouse_left = 1'b0; frame_tick = 1'b0;
    g = exp_goal(int'(x), k);
    m_shots++;
    m_goals += int'(g);
    check_eq("hold_entries", entries, 1);
    check_eq("hold_state", state, 1);
    check_eq("hold_shot_cnt", shot_cnt, m_shots);
    check_eq("hold_goal", goal, g);
    check_eq("hold_goal_cnt", goal_cnt, m_goals);

    do_shot(12'($urandom_range(0, 1100)), 1'b1);
    do_shot(12'($urandom_range(250, 800)), 1'b0);

    repeat (3) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
    end
    check_eq("over_ignores_tick", state, 4);
    click();
    check_eq("over_to_start", state, 0);
    check_eq("held_shot_cnt", shot_cnt, NSHOT);
    check_eq("held_goal_cnt", goal_cnt, m_goals);
    click();
    check_eq("new_game_aim", state, 1);
    check_eq("cleared_counts", {shot_cnt, goal_cnt, goal}, 0);
    m_shots = 0;
    m_goals = 0;

    repeat (3) do_shot(12'($urandom_range(150, 900)), 1'b0);

    // reset mid-flight
    click();
    check_eq("rst_test_flight", state, 2);
    repeat (10) begin
      frame_tick = 1'b1; @(negedge clk);
      frame_tick = 1'b0; @(negedge clk);
    end
    check_eq("flight_cnt_10", flight_cnt, 10);
    rst = 1'b0;
    #1;
    check_eq("async_rst_state", state, 0);
    check_eq("async_rst_pos", {aim_x, keeper_xpos}, 0);
    check_eq("async_rst_counts", {shot_cnt, goal_cnt, goal, flight_cnt}, 0);
    @(negedge clk); rst = 1'b1;
    repeat (20) begin
      frame_tick = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    frame_tick = 1'b0;
    check_eq("stay_start", state, 0);
    m_shots = 0;
    m_goals = 0;
    click();
    check_eq("post_rst_aim", state, 1);
    do_shot(12'($urandom_range(150, 900)), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
